// File: rtl/seg_scan_driver_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : seg_scan_driver_pkg                                          |
// | Description : Shared definitions for the multiplexed 7-segment driver:     |
// |               digit code type, special code values and active-low segment  |
// |               patterns ordered {a,b,c,d,e,f,g,dp} (bit0 = dp), plus a      |
// |               helper that merges the decimal point into a pattern.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seg_scan_driver_pkg;

  typedef logic [3:0] seg_code_t;

  localparam seg_code_t CODE_MINUS = 4'd10;
  localparam seg_code_t CODE_BLANK = 4'd15;

  // Patterns carry dp=1 (off); the decimal point is merged separately.
  localparam logic [7:0] SEG_0     = 8'b0000001_1;
  localparam logic [7:0] SEG_1     = 8'b1001111_1;
  localparam logic [7:0] SEG_2     = 8'b0010010_1;
  localparam logic [7:0] SEG_3     = 8'b0000110_1;
  localparam logic [7:0] SEG_4     = 8'b1001100_1;
  localparam logic [7:0] SEG_5     = 8'b0100100_1;
  localparam logic [7:0] SEG_6     = 8'b0100000_1;
  localparam logic [7:0] SEG_7     = 8'b0001111_1;
  localparam logic [7:0] SEG_8     = 8'b0000000_1;
  localparam logic [7:0] SEG_9     = 8'b0000100_1;
  localparam logic [7:0] SEG_MINUS = 8'b1111110_1;
  localparam logic [7:0] SEG_BLANK = 8'b1111111_1;

  // Clear the active-low dp bit when the decimal point is requested.
  function automatic logic [7:0] seg_apply_dp(input logic [7:0] pat, input logic dp);
    return pat & {7'h7F, ~dp};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_decoder                                                  |
// | Description : Combinational 4-bit code + decimal point to active-low       |
// |               segment bus. Codes 0..9 are digits, 10 is a minus sign,      |
// |               11..15 are blank. The dp is independent of the code.         |
// | Ports       : i_code  [3:0] digit code                                     |
// |               i_dp          1 = light decimal point                        |
// |               o_seg_n [7:0] {a,b,c,d,e,f,g,dp}, active low                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_decoder
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_dp,
  output logic [7:0] o_seg_n
);

  logic [7:0] w_pat;

  always_comb begin
    w_pat = SEG_BLANK;
    case (i_code)
      4'd0:       w_pat = SEG_0;
      4'd1:       w_pat = SEG_1;
      4'd2:       w_pat = SEG_2;
      4'd3:       w_pat = SEG_3;
      4'd4:       w_pat = SEG_4;
      4'd5:       w_pat = SEG_5;
      4'd6:       w_pat = SEG_6;
      4'd7:       w_pat = SEG_7;
      4'd8:       w_pat = SEG_8;
      4'd9:       w_pat = SEG_9;
      CODE_MINUS: w_pat = SEG_MINUS;
      default:    w_pat = SEG_BLANK;
    endcase
  end

  assign o_seg_n = seg_apply_dp(w_pat, i_dp);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg_scan_driver                                              |
// | Description : Time-multiplexed driver for an N-digit common-anode          |
// |               7-segment display. One digit per REFRESH_DIV-cycle slot,     |
// |               anodes held off for the first BLANK_CYCLES of each slot to   |
// |               avoid ghosting. Inputs are snapshotted once per frame so a   |
// |               frame never mixes old and new values.                        |
// | Ports       : clk, rst_n (async, active low)                               |
// |               enable          0 = dark, scan held at digit 0               |
// |               digits[4N-1:0]  digit i code at [4i+3:4i]                    |
// |               dp_mask[N-1:0]  decimal point per digit                      |
// |               seg_n[7:0]      shared segments, active low                  |
// |               an_n[N-1:0]     anode selects, active low                    |
// |               frame_start     pulse when the digit-0 slot begins           |
// | Options     : SEG_LEADING_ZERO_BLANK_EN - blank leading zero digits        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        r_div;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic [7:0]              r_seg_n;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic                    r_frame_start;

  logic                    w_div_last;
  logic                    w_frame_end;
  logic                    w_active;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [3:0]              w_sel_code;
  logic                    w_sel_dp;
  logic [7:0]              w_dec_seg_n;

  assign w_div_last  = (r_div == DIV_LAST);
  assign w_frame_end = w_div_last && (r_idx == IDX_LAST);
  assign w_active    = enable && (r_div >= BLANK_END);

  // Slot divider and digit index; disabled scan parks at digit 0, div 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (!enable) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_div_last) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Inputs are sampled only at a frame boundary (or freely while dark), so
  // every displayed frame comes from one coherent set of values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap    <= '0;
      r_snap_dp <= '0;
    end else if (!enable || w_frame_end) begin
      r_snap    <= digits;
      r_snap_dp <= dp_mask;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; a digit is blanked while it
  // and everything above it is a zero without a decimal point.
  logic w_lz_run;
  always_comb begin
    w_lz_run  = 1'b1;
    w_lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_lz_run     = w_lz_run & (r_snap[4*i +: 4] == 4'd0) & ~r_snap_dp[i];
      w_lz_mask[i] = w_lz_run;
    end
  end
`else
  assign w_lz_mask = '0;
`endif

  // Select the snapshot digit for the current slot.
  always_comb begin
    w_sel_code = '0;
    w_sel_dp   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_code = w_lz_mask[i] ? CODE_BLANK : r_snap[4*i +: 4];
        w_sel_dp   = r_snap_dp[i];
      end
    end
  end

  seg_decoder u_decoder (
    .i_code  (w_sel_code),
    .i_dp    (w_sel_dp),
    .o_seg_n (w_dec_seg_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_n       <= 8'hFF;
      r_an_n        <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_seg_n       <= w_active ? w_dec_seg_n : 8'hFF;
      r_an_n        <= w_active ? ~(NUM_DIGITS'(1) << r_idx) : '1;
      r_frame_start <= enable && (r_idx == '0) && (r_div == '0);
    end
  end

  assign seg_n       = r_seg_n;
  assign an_n        = r_an_n;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg_scan_driver                                           |
// | Description : Directed bench for seg_scan_driver (4 digits, 8-cycle slots, |
// |               2 blank cycles) plus a 1-digit, 2-cycle-slot instance.       |
// |               Honours SEG_LEADING_ZERO_BLANK_EN in its expectations.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_start;

  logic [3:0]  digits1;
  logic        dp1;
  logic [7:0]  seg1;
  logic        an1;
  logic        fs1;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .digits      (digits),
    .dp_mask     (dp_mask),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(2), .BLANK_CYCLES(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .digits      (digits1),
    .dp_mask     (dp1),
    .seg_n       (seg1),
    .an_n        (an1),
    .frame_start (fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [31:0] exp;   // expected seg_n per digit, {d3,d2,d1,d0}
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d actual=%h required=%h", name, n, act, exp);
    end
  endtask

  // Advance one cycle; n is the number of edges since the first enabled edge.
  task automatic check_cycle(input int n, input logic [31:0] exp_seg);
    int         div;
    int         idx;
    logic       lit;
    logic [3:0] one;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    step();
    div   = n % 8;
    idx   = (n / 8) % 4;
    lit   = (div >= 2);
    one   = 4'b0001;
    e_an  = lit ? ~(one << idx) : 4'hF;
    e_seg = lit ? exp_seg[8*idx +: 8] : 8'hFF;
    chk("an_n", n, {28'd0, an_n}, {28'd0, e_an});
    chk("seg_n", n, {24'd0, seg_n}, {24'd0, e_seg});
    chk("frame_start", n, {31'd0, frame_start}, {31'd0, (div == 0 && idx == 0)});
  endtask

  initial begin
    vecs[0] = '{16'h9810, 4'b0000, 32'h09019F03};
    vecs[1] = '{16'hFA00, 4'b1000, 32'hFEFD0303};
    vecs[2] = '{16'h1234, 4'b0000, 32'h9F250D99};
    vecs[3] = '{16'h5678, 4'b0101, 32'h49401F00};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    vecs[4] = '{16'h0042, 4'b0000, 32'hFFFF9925};
    vecs[6] = '{16'h0007, 4'b0100, 32'hFF02031F};
`else
    vecs[4] = '{16'h0042, 4'b0000, 32'h03039925};
    vecs[6] = '{16'h0007, 4'b0100, 32'h0302031F};
`endif
    vecs[5] = '{16'hBCDE, 4'b0001, 32'hFFFFFFFE};

    rst_n   = 1'b0;
    enable  = 1'b0;
    digits  = 16'h0000;
    dp_mask = 4'b0000;
    digits1 = 4'h7;
    dp1     = 1'b0;
    step();
    step();
    chk("reset_seg", 0, {24'd0, seg_n}, 32'h0000_00FF);
    chk("reset_an", 0, {28'd0, an_n}, 32'h0000_000F);
    chk("reset_fs", 0, {31'd0, frame_start}, 32'd0);
    rst_n = 1'b1;

    // Decode table: load each pattern while dark, then scan one frame.
    for (int v = 0; v < 7; v++) begin
      enable  = 1'b0;
      digits  = vecs[v].dig;
      dp_mask = vecs[v].dp;
      step();
      chk("dark_seg", v, {24'd0, seg_n}, 32'h0000_00FF);
      enable = 1'b1;
      for (int n = 0; n < 32; n++) check_cycle(n, vecs[v].exp);
    end

    // No tearing: change inputs during slot 2, old frame must finish intact.
    enable  = 1'b0;
    digits  = 16'h1234;
    dp_mask = 4'b0000;
    step();
    enable = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (n == 18) digits = 16'h9810;
      check_cycle(n, (n < 32) ? 32'h9F250D99 : 32'h09019F03);
    end

    // Enable drop in slot 1, then restart from digit 0.
    enable = 1'b0;
    step();
    enable = 1'b1;
    for (int n = 0; n < 10; n++) check_cycle(n, 32'h09019F03);
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("dis_seg", k, {24'd0, seg_n}, 32'h0000_00FF);
      chk("dis_an", k, {28'd0, an_n}, 32'h0000_000F);
      chk("dis_fs", k, {31'd0, frame_start}, 32'd0);
    end
    enable = 1'b1;
    for (int n = 0; n < 16; n++) begin
      check_cycle(n, 32'h09019F03);
      chk("d1_an", n, {31'd0, an1}, {31'd0, (n % 2 == 0)});
      chk("d1_seg", n, {24'd0, seg1}, (n % 2 == 1) ? 32'h0000_001F : 32'h0000_00FF);
      chk("d1_fs", n, {31'd0, fs1}, {31'd0, (n % 2 == 0)});
    end

    // Asynchronous reset mid-slot: dark immediately, restart at digit 0.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", 0, {24'd0, seg_n}, 32'h0000_00FF);
    chk("arst_an", 0, {28'd0, an_n}, 32'h0000_000F);
    chk("arst_fs", 0, {31'd0, frame_start}, 32'd0);
    step();
    step();
    chk("arst_hold_an", 0, {28'd0, an_n}, 32'h0000_000F);
    rst_n = 1'b1;
    // Snapshot was cleared by reset, so the first frame shows all zeros.
`ifdef SEG_LEADING_ZERO_BLANK_EN
    for (int n = 0; n < 32; n++) check_cycle(n, 32'hFFFFFF03);
`else
    for (int n = 0; n < 32; n++) check_cycle(n, 32'h03030303);
`endif
    for (int n = 32; n < 40; n++) check_cycle(n, 32'h09019F03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
